// File: rtl/mem_stream_responder.sv
// Word-addressed scratchpad behind a valid/ready request port with a fixed-latency,
// no-backpressure response. Define MEM_STREAM_RESPONDER_STALL_EN for LFSR request stalls.
module mem_stream_responder #(
  parameter int NumWords  = 256,
  parameter int DataWidth = 32,
  parameter int Latency   = 1,
  localparam int AddrWidth = $clog2(NumWords),
  localparam int StrbWidth = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [StrbWidth-1:0] req_be_i,
  output logic                 resp_valid_o,
  output logic [DataWidth-1:0] resp_rdata_o,
  output logic                 resp_err_o
);

  localparam logic [AddrWidth:0] NumWordsExt = (AddrWidth + 1)'(NumWords);

  // Handshake: a request is taken on a rising edge where req_valid_i & req_ready_o;
  // the payload only has to be stable in that cycle. Every taken request yields one
  // single-cycle resp_valid_o pulse Latency cycles later; the response side cannot stall.
  logic                 req_acc;
  logic                 addr_ok;
  logic [DataWidth-1:0] rd_data;
  logic                 rd_err;
  logic [DataWidth-1:0] mem_q [NumWords];
  logic [DataWidth-1:0] mem_d [NumWords];

  assign req_acc = req_valid_i & req_ready_o;
  assign addr_ok = {1'b0, req_addr_i} < NumWordsExt;

`ifdef MEM_STREAM_RESPONDER_STALL_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign req_ready_o = rst_ni & (lfsr_q[1:0] != 2'b00);
`else
  assign req_ready_o = rst_ni;
`endif

  // Read data is sampled from the array state before this edge's write lands.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (req_acc) begin
      rd_err = ~addr_ok;
      if (!req_we_i && addr_ok) begin
        rd_data = mem_q[req_addr_i];
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (req_acc && req_we_i && addr_ok) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (req_be_i[b]) begin
          mem_d[req_addr_i][b*8 +: 8] = req_wdata_i[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumWords; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  generate
    if (Latency == 0) begin : g_comb
      assign resp_valid_o = req_acc;
      assign resp_rdata_o = rd_data;
      assign resp_err_o   = rd_err;
    end else begin : g_pipe
      logic [Latency-1:0]   vld_q;
      logic [Latency-1:0]   vld_d;
      logic [Latency-1:0]   err_q;
      logic [Latency-1:0]   err_d;
      logic [DataWidth-1:0] rdata_q [Latency];
      logic [DataWidth-1:0] rdata_d [Latency];

      // Stage 0 loads every cycle; idle cycles carry zeros so outputs are 0 between pulses.
      always_comb begin
        vld_d[0]   = req_acc;
        err_d[0]   = rd_err;
        rdata_d[0] = rd_data;
        for (int i = 1; i < Latency; i++) begin
          vld_d[i]   = vld_q[i-1];
          err_d[i]   = err_q[i-1];
          rdata_d[i] = rdata_q[i-1];
        end
      end

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          vld_q <= '0;
          err_q <= '0;
          for (int i = 0; i < Latency; i++) begin
            rdata_q[i] <= '0;
          end
        end else begin
          vld_q   <= vld_d;
          err_q   <= err_d;
          rdata_q <= rdata_d;
        end
      end

      assign resp_valid_o = vld_q[Latency-1];
      assign resp_rdata_o = rdata_q[Latency-1];
      assign resp_err_o   = err_q[Latency-1];
    end
  endgenerate

endmodule

// File: tb/tb_mem_stream_responder.sv
// Bench for mem_stream_responder: four instances (Latency 0/1/3/4, NumWords 200) share
// one request stream and are compared against a memory model delayed by each latency.
module tb_mem_stream_responder;

  localparam int N  = 200;
  localparam int DW = 32;
  localparam int AW = $clog2(N);
  localparam int SW = DW / 8;
  localparam int NV = 14;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic          e;
  } rsp_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] be;
    logic [DW-1:0] exp_d;
    logic          exp_e;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_be;
  logic [3:0]    rdy;
  logic [3:0]    rv;
  logic [3:0]    re;
  logic [DW-1:0] rd [4];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 100;
  bit chk_en   = 0;
  bit sb_en    = 0;
  int tot_acc  = 0;
  int tot_resp [4] = '{0, 0, 0, 0};

  rsp_t          hist [64];
  logic [DW-1:0] mdl_mem [N];
  logic [DW-1:0] exp_q [$];
`ifdef MEM_STREAM_RESPONDER_STALL_EN
  logic [15:0]   lfsr_m = 16'hACE1;
`endif

  function automatic int lat_of(input int i);
    case (i)
      0: return 0;
      1: return 1;
      2: return 3;
      default: return 4;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 4;
    mem_stream_responder #(
      .NumWords (N),
      .DataWidth(DW),
      .Latency  (L)
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (rdy[g]),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_be_i    (req_be),
      .resp_valid_o(rv[g]),
      .resp_rdata_o(rd[g]),
      .resp_err_o  (re[g])
    );
  end

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 60) $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: array of words plus a per-cycle response history, read back at
  // each instance's latency. Reset wipes the array and every response still owed.
  always @(negedge clk) begin : mon
    rsp_t exp_now;
    rsp_t exp_old;
    logic exp_rdy;
    logic acc;
    int   a;
    cyc++;
`ifdef MEM_STREAM_RESPONDER_STALL_EN
    exp_rdy = rst_n && (lfsr_m[1:0] != 2'b00);
`else
    exp_rdy = rst_n;
`endif
    acc = req_valid && exp_rdy;
    a   = int'(req_addr);
    exp_now = '0;
    if (acc) begin
      exp_now.v = 1'b1;
      exp_now.e = (a >= N);
      if (!req_we && a < N) exp_now.d = mdl_mem[a];
    end
    hist[cyc % 64] = exp_now;
    if (chk_en) begin
      if (acc) tot_acc++;
      for (int i = 0; i < 4; i++) begin
        exp_old = hist[(cyc - lat_of(i)) % 64];
        check_val($sformatf("resp_lat%0d", lat_of(i)), 64'({rv[i], rd[i], re[i]}), 64'(exp_old));
        check_val($sformatf("ready_lat%0d", lat_of(i)), 64'(rdy[i]), 64'(exp_rdy));
        if (rv[i]) tot_resp[i]++;
      end
    end
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) hist[(cyc - k) % 64] = '0;
      for (int j = 0; j < N; j++) mdl_mem[j] = '0;
`ifdef MEM_STREAM_RESPONDER_STALL_EN
      lfsr_m = 16'hACE1;
`endif
      chk_en = 1'b1;
    end else begin
      if (acc && req_we && a < N) begin
        for (int b = 0; b < SW; b++) begin
          if (req_be[b]) mdl_mem[a][b*8 +: 8] = req_wdata[b*8 +: 8];
        end
      end
`ifdef MEM_STREAM_RESPONDER_STALL_EN
      lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
`endif
    end
  end

  // Scoreboard on the Latency=3 instance for the ordered back-to-back sequence
  always @(negedge clk) begin : sb
    logic [DW-1:0] e;
    if (sb_en && rv[2]) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected_resp: got response %h, expected none", rd[2]);
      end else begin
        e = exp_q.pop_front();
        check_val("sb_rdata_lat3", 64'(rd[2]), 64'(e));
      end
    end
  end

  // Driver tasks: called at posedge+1, return at posedge+1 after acceptance
  task automatic drive_req(input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [SW-1:0] be,
                           input logic [DW-1:0] exp_d);
    int w = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(negedge clk);
    while (!rdy[0] && w < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      w++;
    end
    if (!rdy[0]) check_val("accept_timeout", 64'(rdy[0]), 64'd1);
    else if (sb_en) exp_q.push_back(exp_d);
    @(posedge clk); #1;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    int w = 0;
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_be    = v.be;
    @(negedge clk);
    while (!rdy[0] && w < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      w++;
    end
    if (!rdy[0]) check_val($sformatf("vec%0d_accept", idx), 64'(rdy[0]), 64'd1);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (lat_of(i) == k)
          check_val($sformatf("vec%0d_lat%0d", idx, k), 64'({rv[i], rd[i], re[i]}),
                    64'({1'b1, v.exp_d, v.exp_e}));
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  initial begin
    vec_t vecs [NV];
    int   cnt;
    int   cycles;
    int   start_acc;
    int   start_resp [4];

    vecs[0]  = '{1'b1, 8'd5,   32'hDEADBEEF, 4'hF,    32'h0,        1'b0};
    vecs[1]  = '{1'b0, 8'd5,   32'h0,        4'h0,    32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 8'd3,   32'h11223344, 4'hF,    32'h0,        1'b0};
    vecs[3]  = '{1'b1, 8'd3,   32'hAABBCCDD, 4'b0101, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 8'd3,   32'h0,        4'h0,    32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b0, 8'd250, 32'h0,        4'h0,    32'h0,        1'b1};
    vecs[6]  = '{1'b1, 8'd250, 32'hFFFFFFFF, 4'hF,    32'h0,        1'b1};
    vecs[7]  = '{1'b0, 8'd250, 32'h0,        4'h0,    32'h0,        1'b1};
    vecs[8]  = '{1'b0, 8'd199, 32'h0,        4'h0,    32'h0,        1'b0};
    vecs[9]  = '{1'b1, 8'd199, 32'h12345678, 4'b1000, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 8'd199, 32'h0,        4'h0,    32'h12000000, 1'b0};
    vecs[11] = '{1'b0, 8'd200, 32'h0,        4'h0,    32'h0,        1'b1};
    vecs[12] = '{1'b1, 8'd0,   32'hFFFFFFFF, 4'h0,    32'h0,        1'b0};
    vecs[13] = '{1'b0, 8'd0,   32'h0,        4'h0,    32'h0,        1'b0};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_resp_valid", 64'(rv), 64'd0);
    check_val("reset_resp_err", 64'(re), 64'd0);
    check_val("reset_ready", 64'(rdy), 64'd0);
    for (int i = 0; i < 4; i++) check_val($sformatf("reset_rdata_%0d", i), 64'(rd[i]), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("ready_first_cycle", 64'(rdy), 64'hF);
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < NV; i++) apply_vec(vecs[i], i);

    // Back-to-back writes then reads, ordered, plus write/read of one address in adjacent cycles
    sb_en = 1'b1;
    for (int i = 0; i < 20; i++) drive_req(1'b1, AW'(i), DW'(i * 3), 4'hF, '0);
    for (int i = 0; i < 20; i++) drive_req(1'b0, AW'(i), '0, '0, DW'(i * 3));
    drive_req(1'b1, 8'd7, 32'h0BADF00D, 4'hF, '0);
    drive_req(1'b0, 8'd7, '0, '0, 32'h0BADF00D);
    req_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    sb_en = 1'b0;
    check_val("sb_drained", 64'(exp_q.size()), 64'd0);

    // Reset with requests in flight
    drive_req(1'b1, 8'd9, 32'hCAFEF00D, 4'hF, '0);
    for (int i = 0; i < 4; i++) drive_req(1'b0, 8'd9, '0, '0, '0);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      cnt += $countones(rv);
      @(posedge clk); #1;
    end
    check_val("no_stale_after_reset", 64'(cnt), 64'd0);
    apply_vec('{1'b0, 8'd9, 32'h0, 4'h0, 32'h0, 1'b0}, 99);

    // Random traffic against the model
    start_acc = tot_acc;
    for (int i = 0; i < 4; i++) start_resp[i] = tot_resp[i];
    cycles = 0;
    while (tot_acc - start_acc < 10000 && cycles < 40000) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom_range(0, 215));
      req_wdata = $urandom();
      req_be    = SW'($urandom_range(0, 15));
      @(posedge clk); #1;
      cycles++;
    end
    req_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check_val("rand_accepted", 64'(tot_acc - start_acc), 64'd10000);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("rand_resp_count_lat%0d", lat_of(i)),
                64'(tot_resp[i] - start_resp[i]), 64'(tot_acc - start_acc));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
